// File: rtl/cfu_cmd_issuer_if.sv
// ============================================================================
// Module      : cfu_cmd_issuer_if
// Description : Upstream request/result and CFU command/response bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cfu_cmd_issuer_if;
    // Upstream request side
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_function_id;
    logic [31:0] req_inputs_0;
    logic [31:0] req_inputs_1;
    // Upstream result side
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_timeout;
    // CFU command side
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    // CFU response side
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    // Status
    logic        busy;
    logic [15:0] issued_count;

    // Issuer view
    modport master (
        input  req_valid, req_function_id, req_inputs_0, req_inputs_1,
        output req_ready,
        output res_valid, res_data, res_timeout,
        input  res_ready,
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1,
        input  cmd_ready,
        input  rsp_valid, rsp_payload_outputs_0,
        output rsp_ready,
        output busy, issued_count
    );

    // Environment view: upstream requester plus the CFU itself
    modport slave (
        output req_valid, req_function_id, req_inputs_0, req_inputs_1,
        input  req_ready,
        input  res_valid, res_data, res_timeout,
        output res_ready,
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1,
        output cmd_ready,
        output rsp_valid, rsp_payload_outputs_0,
        input  rsp_ready,
        input  busy, issued_count
    );
endinterface

`default_nettype wire

// File: rtl/cfu_cmd_issuer.sv
// ============================================================================
// Module      : cfu_cmd_issuer
// Description : Buffers upstream commands and issues them one at a time to a
//               CFU, returning each response (or a timeout marker) in order.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cfu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cfu_cmd_issuer_if.master   bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int EW = 10 + 32 + 32;

    localparam logic [AW:0]    c_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0]  c_TMO   = CW'(TIMEOUT);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_WAIT_RSP = 2'd2;
    localparam logic [1:0] c_DELIVER  = 2'd3;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          w_cmd_valid;
    logic          w_rsp_ready;
    logic          w_res_valid;

    logic [9:0]    r_cmd_fid;
    logic [31:0]   r_cmd_in0;
    logic [31:0]   r_cmd_in1;
    logic [31:0]   r_res_data;
    logic          r_res_timeout;
    logic [CW-1:0] r_tmo_cnt;
    logic          r_stale;
    logic [15:0]   r_issued_count;
    logic          w_tmo_hit;

    // Full blocks writes even when a pop lands in the same cycle.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.req_valid && !w_full;
    assign w_pop   = w_cmd_valid && bus.cmd_ready;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.req_function_id, bus.req_inputs_0, bus.req_inputs_1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue state machine
    // ------------------------------------------------------------------
    assign w_tmo_hit = (r_tmo_cnt == c_TMO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (!w_empty && !r_stale) begin
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (bus.cmd_ready) begin
                    w_state_nxt = c_WAIT_RSP;
                end
            end
            c_WAIT_RSP: begin
                if (bus.rsp_valid || w_tmo_hit) begin
                    w_state_nxt = c_DELIVER;
                end
            end
            c_DELIVER: begin
                if (bus.res_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // A stale command's late beat must be drained from any state.
    always_comb begin
        w_cmd_valid = 1'b0;
        w_rsp_ready = r_stale;
        w_res_valid = 1'b0;
        case (r_state)
            c_ISSUE:    w_cmd_valid = 1'b1;
            c_WAIT_RSP: w_rsp_ready = 1'b1;
            c_DELIVER:  w_res_valid = 1'b1;
            default:    ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_fid      <= '0;
            r_cmd_in0      <= '0;
            r_cmd_in1      <= '0;
            r_res_data     <= '0;
            r_res_timeout  <= 1'b0;
            r_tmo_cnt      <= '0;
            r_stale        <= 1'b0;
            r_issued_count <= '0;
        end else begin
            if (r_state == c_IDLE && !w_empty) begin
                {r_cmd_fid, r_cmd_in0, r_cmd_in1} <= w_head;
            end

            if (w_pop) begin
                r_tmo_cnt      <= '0;
                r_issued_count <= r_issued_count + 16'd1;
            end else if (r_state == c_WAIT_RSP && !w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + CW'(1);
            end

            // The response wins a same-cycle collision with the timeout.
            if (r_state == c_WAIT_RSP) begin
                if (bus.rsp_valid) begin
                    r_res_data    <= bus.rsp_payload_outputs_0;
                    r_res_timeout <= 1'b0;
                end else if (w_tmo_hit) begin
                    r_res_data    <= 32'hFFFF_FFFF;
                    r_res_timeout <= 1'b1;
                    r_stale       <= 1'b1;
                end
            end else if (r_stale && bus.rsp_valid) begin
                r_stale <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign bus.req_ready               = !w_full;
    assign bus.res_valid               = w_res_valid;
    assign bus.res_data                = r_res_data;
    assign bus.res_timeout             = r_res_timeout;
    assign bus.cmd_valid               = w_cmd_valid;
    assign bus.cmd_payload_function_id = r_cmd_fid;
    assign bus.cmd_payload_inputs_0    = r_cmd_in0;
    assign bus.cmd_payload_inputs_1    = r_cmd_in1;
    assign bus.rsp_ready               = w_rsp_ready;
    assign bus.busy                    = !w_empty || (r_state != c_IDLE);
    assign bus.issued_count            = r_issued_count;

endmodule

`default_nettype wire

// File: tb/tb_cfu_cmd_issuer.sv
// ============================================================================
// Module      : tb_cfu_cmd_issuer
// Description : Directed self-checking bench for cfu_cmd_issuer (DEPTH=4, TIMEOUT=8).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cfu_cmd_issuer;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    cfu_cmd_issuer_if bus ();

    cfu_cmd_issuer #(
        .DEPTH   (4),
        .TIMEOUT (8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; a request handshaken on this edge is withdrawn.
    task automatic step();
        logic acc;
        acc = bus.req_valid && bus.req_ready;
        @(posedge clk);
        #1;
        if (acc) bus.req_valid = 1'b0;
    endtask

    task automatic set_req(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
        bus.req_function_id = fid;
        bus.req_inputs_0    = a;
        bus.req_inputs_1    = b;
        bus.req_valid       = 1'b1;
    endtask

    task automatic wait_cmd(input string tag);
        int n;
        n = 0;
        while (!bus.cmd_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'd0, bus.cmd_valid}, 32'd1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset                     = 1'b1;
        bus.req_valid             = 1'b0;
        bus.req_function_id       = '0;
        bus.req_inputs_0          = '0;
        bus.req_inputs_1          = '0;
        bus.res_ready             = 1'b0;
        bus.cmd_ready             = 1'b0;
        bus.rsp_valid             = 1'b0;
        bus.rsp_payload_outputs_0 = '0;
        #1;

        // ---------------- reset values ----------------
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_rsp_ready", {31'd0, bus.rsp_ready}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_issued", {16'd0, bus.issued_count}, 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // ---------------- single command ----------------
        bus.cmd_ready = 1'b1;
        set_req(10'h009, 32'd5, 32'hDEAD_BEEF);
        step();
        chk("t1_cyc1_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        chk("t1_cyc1_busy", {31'd0, bus.busy}, 32'd1);
        step();
        chk("t1_cyc2_cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
        chk("t1_fid", {22'd0, bus.cmd_payload_function_id}, 32'h009);
        chk("t1_in0", bus.cmd_payload_inputs_0, 32'd5);
        chk("t1_in1", bus.cmd_payload_inputs_1, 32'hDEAD_BEEF);
        step();
        chk("t1_wait_rsp_ready", {31'd0, bus.rsp_ready}, 32'd1);
        chk("t1_wait_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        chk("t1_issued", {16'd0, bus.issued_count}, 32'd1);
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_payload_outputs_0 = 32'd101;
        step();
        bus.rsp_valid = 1'b0;
        chk("t1_res_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("t1_res_data", bus.res_data, 32'd101);
        chk("t1_res_timeout", {31'd0, bus.res_timeout}, 32'd0);
        chk("t1_deliver_rsp_ready", {31'd0, bus.rsp_ready}, 32'd0);
        bus.res_ready = 1'b1;
        step();
        chk("t1_idle_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("t1_idle_busy", {31'd0, bus.busy}, 32'd0);

        // ---------------- FIFO full ----------------
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_req_ready_fill", {31'd0, bus.req_ready}, 32'd1);
            set_req(10'h100 + 10'(i), 32'h1000 + i, 32'h2000 + i);
            step();
        end
        set_req(10'h104, 32'h1004, 32'h2004);
        chk("t2_req_ready_full", {31'd0, bus.req_ready}, 32'd0);
        step();
        step();
        chk("t2_still_full", {31'd0, bus.req_ready}, 32'd0);
        chk("t2_stall_cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
        chk("t2_stall_fid", {22'd0, bus.cmd_payload_function_id}, 32'h100);
        chk("t2_stall_issued", {16'd0, bus.issued_count}, 32'd1);
        bus.cmd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_cmd("t2_wait_cmd");
            chk("t2_fid", {22'd0, bus.cmd_payload_function_id}, 32'h100 + k);
            chk("t2_in0", bus.cmd_payload_inputs_0, 32'h1000 + k);
            chk("t2_in1", bus.cmd_payload_inputs_1, 32'h2000 + k);
            if (k == 0) chk("t2_full_on_pop", {31'd0, bus.req_ready}, 32'd0);
            step();
            bus.rsp_valid = 1'b1;
            bus.rsp_payload_outputs_0 = 32'h5000 + k;
            step();
            bus.rsp_valid = 1'b0;
            chk("t2_res_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("t2_res_data", bus.res_data, 32'h5000 + k);
            chk("t2_res_timeout", {31'd0, bus.res_timeout}, 32'd0);
            step();
        end
        chk("t2_issued", {16'd0, bus.issued_count}, 32'd6);
        chk("t2_busy", {31'd0, bus.busy}, 32'd0);

        // ---------------- upstream backpressure ----------------
        bus.res_ready = 1'b0;
        set_req(10'h033, 32'd7, 32'd8);
        step();
        wait_cmd("t3_wait_cmd_x");
        chk("t3_fid_x", {22'd0, bus.cmd_payload_function_id}, 32'h033);
        step();
        set_req(10'h034, 32'd9, 32'd10);
        bus.rsp_valid = 1'b1;
        bus.rsp_payload_outputs_0 = 32'd55;
        step();
        bus.rsp_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("t3_hold_res_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("t3_hold_res_data", bus.res_data, 32'd55);
            chk("t3_hold_no_cmd", {31'd0, bus.cmd_valid}, 32'd0);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        chk("t3_m1_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        chk("t3_m1_res_valid", {31'd0, bus.res_valid}, 32'd0);
        step();
        chk("t3_m2_cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
        chk("t3_fid_y", {22'd0, bus.cmd_payload_function_id}, 32'h034);
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_payload_outputs_0 = 32'd66;
        step();
        bus.rsp_valid = 1'b0;
        chk("t3_res_data_y", bus.res_data, 32'd66);
        step();

        // ---------------- timeout and stale drain ----------------
        bus.res_ready = 1'b0;
        set_req(10'h021, 32'd1, 32'd2);
        step();
        set_req(10'h022, 32'd3, 32'd4);
        wait_cmd("t4_wait_cmd_a");
        chk("t4_fid_a", {22'd0, bus.cmd_payload_function_id}, 32'h021);
        step();
        for (int c = 1; c <= 9; c++) begin
            chk("t4_wait_res_valid", {31'd0, bus.res_valid}, 32'd0);
            chk("t4_wait_rsp_ready", {31'd0, bus.rsp_ready}, 32'd1);
            step();
        end
        chk("t4_to_res_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("t4_to_res_data", bus.res_data, 32'hFFFF_FFFF);
        chk("t4_to_res_timeout", {31'd0, bus.res_timeout}, 32'd1);
        chk("t4_to_stale_rsp_ready", {31'd0, bus.rsp_ready}, 32'd1);
        bus.res_ready = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            chk("t4_stale_no_cmd", {31'd0, bus.cmd_valid}, 32'd0);
            chk("t4_stale_rsp_ready", {31'd0, bus.rsp_ready}, 32'd1);
            step();
        end
        bus.rsp_valid = 1'b1;
        bus.rsp_payload_outputs_0 = 32'h77;
        step();
        bus.rsp_valid = 1'b0;
        chk("t4_drained_rsp_ready", {31'd0, bus.rsp_ready}, 32'd0);
        chk("t4_drained_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("t4_drained_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        step();
        chk("t4_b_cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
        chk("t4_fid_b", {22'd0, bus.cmd_payload_function_id}, 32'h022);
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_payload_outputs_0 = 32'h99;
        step();
        bus.rsp_valid = 1'b0;
        chk("t4_b_res_data", bus.res_data, 32'h99);
        chk("t4_b_res_timeout", {31'd0, bus.res_timeout}, 32'd0);
        step();

        // ---------------- response vs timeout collision ----------------
        set_req(10'h0C5, 32'd5, 32'd6);
        step();
        wait_cmd("t5_wait_cmd");
        step();
        repeat (8) step();
        chk("t5_pre_res_valid", {31'd0, bus.res_valid}, 32'd0);
        bus.rsp_valid = 1'b1;
        bus.rsp_payload_outputs_0 = 32'h1234;
        step();
        bus.rsp_valid = 1'b0;
        chk("t5_res_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("t5_res_data", bus.res_data, 32'h1234);
        chk("t5_res_timeout", {31'd0, bus.res_timeout}, 32'd0);
        chk("t5_no_stale", {31'd0, bus.rsp_ready}, 32'd0);
        step();
        chk("t5_idle_no_stale", {31'd0, bus.rsp_ready}, 32'd0);

        // ---------------- reset mid-flight ----------------
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(10'h060 + 10'(i), 32'd20 + i, 32'd40 + i);
            step();
        end
        bus.cmd_ready = 1'b1;
        wait_cmd("t6_wait_cmd");
        step();
        bus.cmd_ready = 1'b0;
        chk("t6_wait_rsp_ready", {31'd0, bus.rsp_ready}, 32'd1);
        chk("t6_pre_issued", {16'd0, bus.issued_count}, 32'd12);
        chk("t6_pre_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("t6_rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        chk("t6_rst_rsp_ready", {31'd0, bus.rsp_ready}, 32'd0);
        chk("t6_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("t6_rst_issued", {16'd0, bus.issued_count}, 32'd0);
        chk("t6_rst_res_data", bus.res_data, 32'd0);
        chk("t6_rst_in0", bus.cmd_payload_inputs_0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_payload_outputs_0 = 32'hBAD;
        for (int c = 0; c < 3; c++) begin
            chk("t6_post_rsp_ready", {31'd0, bus.rsp_ready}, 32'd0);
            chk("t6_post_res_valid", {31'd0, bus.res_valid}, 32'd0);
            chk("t6_post_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
            chk("t6_post_busy", {31'd0, bus.busy}, 32'd0);
            step();
        end
        bus.rsp_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
